// File: rtl/ref_freq_detector_if.sv
// Reference-input bundle of the lock-in reference frequency detector.
// The reference source drives ref_in; the detector returns its measurements.
interface ref_freq_detector_if #(
    parameter int CNT_W = 17
);
    logic             ref_in;
    logic             edge_strobe;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic [2:0]       freq;
    logic             locked;
    logic             timeout;

    modport master (
        output ref_in,
        input  edge_strobe, period, period_valid, freq, locked, timeout
    );

    modport slave (
        input  ref_in,
        output edge_strobe, period, period_valid, freq, locked, timeout
    );
endinterface

// File: rtl/ref_freq_detector.sv
// Measures the period of the external TTL reference and classifies it into the
// 3-bit oscillator frequency code, locking after LOCK_N consecutive matches.
module ref_freq_detector #(
    parameter int CNT_W  = 17,
    parameter int LOCK_N = 4
) (
    input  logic               clk,
    input  logic               rst,
    ref_freq_detector_if.slave bus
);
    localparam int MCNT_W = $clog2(LOCK_N + 1);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [MCNT_W-1:0] MCNT_LOCK = MCNT_W'(LOCK_N);

    // Inclusive +/-10 % windows around 36 MHz / f_nominal for each code.
    function automatic logic [31:0] win_lo(input int code);
        case (code)
            0:       return 32'd64800;
            1:       return 32'd32400;
            2:       return 32'd16200;
            3:       return 32'd6480;
            4:       return 32'd3240;
            5:       return 32'd1620;
            6:       return 32'd648;
            default: return 32'd324;
        endcase
    endfunction

    function automatic logic [31:0] win_hi(input int code);
        case (code)
            0:       return 32'd79200;
            1:       return 32'd39600;
            2:       return 32'd19800;
            3:       return 32'd7920;
            4:       return 32'd3960;
            5:       return 32'd1980;
            6:       return 32'd792;
            default: return 32'd396;
        endcase
    endfunction

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              dly_q, dly_d;
    logic              rise_q, rise_d;
    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              pv_q, pv_d;
    logic              es_q, es_d;
    logic              to_q, to_d;
    logic [2:0]        cand_q, cand_d;
    logic [MCNT_W-1:0] mcnt_q, mcnt_d;
    logic [2:0]        freq_q, freq_d;
    logic              locked_q, locked_d;

    logic [31:0]       period_ext;
    logic [7:0]        in_win;
    logic              win_hit;
    logic [2:0]        win_code;
    logic              sat;
    logic [2:0]        cand_new;
    logic [MCNT_W-1:0] mcnt_new;

    assign period_ext = 32'(period_q);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_win
            assign in_win[gi] = (period_ext >= win_lo(gi)) && (period_ext <= win_hi(gi));
        end
    endgenerate

    always_comb begin
        win_hit  = |in_win;
        win_code = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (in_win[i]) win_code = 3'(i);
        end
    end

    // Saturation is flagged on the cycle the counter would step onto CNT_MAX.
    assign sat = (cnt_q >= (CNT_MAX - 1'b1));

    always_comb begin
        sync1_d  = bus.ref_in;
        sync2_d  = sync1_q;
        dly_d    = sync2_q;
        rise_d   = sync2_q & ~dly_q;

        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        pv_d     = 1'b0;
        es_d     = 1'b0;
        to_d     = 1'b0;
        cand_d   = cand_q;
        mcnt_d   = mcnt_q;
        freq_d   = freq_q;
        locked_d = locked_q;
        cand_new = cand_q;
        mcnt_new = mcnt_q;

        case (state_q)
            ST_IDLE: begin
                if (rise_q) begin
                    es_d    = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_MEASURE;
                end
            end
            default: begin
                if (rise_q) begin
                    es_d     = 1'b1;
                    pv_d     = 1'b1;
                    period_d = sat ? CNT_MAX : cnt_q;
                    cnt_d    = CNT_W'(1);
                end else if (sat) begin
                    to_d     = 1'b1;
                    locked_d = 1'b0;
                    mcnt_d   = '0;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        // Classification runs on the cycle after period_valid, from the stored period.
        if (pv_q) begin
            if (win_hit) begin
                if (win_code == cand_q) begin
                    cand_new = cand_q;
                    mcnt_new = (mcnt_q == MCNT_LOCK) ? mcnt_q : mcnt_q + 1'b1;
                end else begin
                    cand_new = win_code;
                    mcnt_new = MCNT_W'(1);
                end
                cand_d   = cand_new;
                mcnt_d   = mcnt_new;
                locked_d = (mcnt_new == MCNT_LOCK);
                if (mcnt_new == MCNT_LOCK) freq_d = cand_new;
            end else begin
                mcnt_d   = '0;
                locked_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            dly_q    <= 1'b0;
            rise_q   <= 1'b0;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            es_q     <= 1'b0;
            to_q     <= 1'b0;
            cand_q   <= 3'd1;
            mcnt_q   <= '0;
            freq_q   <= 3'd1;
            locked_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            dly_q    <= dly_d;
            rise_q   <= rise_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            es_q     <= es_d;
            to_q     <= to_d;
            cand_q   <= cand_d;
            mcnt_q   <= mcnt_d;
            freq_q   <= freq_d;
            locked_q <= locked_d;
        end
    end

    assign bus.edge_strobe  = es_q;
    assign bus.period       = period_q;
    assign bus.period_valid = pv_q;
    assign bus.freq         = freq_q;
    assign bus.locked       = locked_q;
    assign bus.timeout      = to_q;
endmodule
